issue_sched: RTL and testbench

ISSUE_SCHED -- requirements
Module: issue_sched

---
 rtl/issue_sched.sv | 176 +++++++++++++++++
 tb/tb_issue_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_sched.sv
// In-order issue scheduler: a small instruction FIFO whose head is checked against a
// 64-entry register scoreboard and dispatched to one free execution unit per cycle.
module issue_sched #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NUM_ALU = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic               i_in_type,
  input  logic [2:0]         i_in_unit,
  input  logic [5:0]         i_in_r1_rn,
  input  logic [5:0]         i_in_r2_rn,
  input  logic [5:0]         i_in_rd_rn,
  input  logic [5:0]         i_in_rd2_rn,
  input  logic               i_flush,
  input  logic               i_wb0_en,
  input  logic [5:0]         i_wb0_rn,
  input  logic               i_wb1_en,
  input  logic [5:0]         i_wb1_rn,
  output logic [NUM_ALU-1:0] o_alu_en,
  input  logic [NUM_ALU-1:0] i_alu_busy,
  output logic               o_advint_en,
  output logic               o_memunit_en,
  output logic               o_branch_en,
  input  logic               i_advint_busy,
  input  logic               i_memunit_busy,
  input  logic               i_branch_busy,
  output logic [5:0]         o_rd_out_rn,
  output logic [5:0]         o_rd2_out_rn,
  output logic [5:0]         o_r1_out_rn,
  output logic [5:0]         o_r2_out_rn,
  output logic               o_illegal,
  output logic [63:0]        o_reg_busy
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic       typ;
    logic [2:0] unit;
    logic [5:0] r1;
    logic [5:0] r2;
    logic [5:0] rd;
    logic [5:0] rd2;
  } entry_t;

  entry_t              r_queue [DEPTH];
  logic [PtrW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]     r_count;
  logic [63:0]         r_reg_busy;
  logic [NUM_ALU-1:0]  r_alu_en;
  logic                r_advint_en, r_memunit_en, r_branch_en, r_illegal;
  logic [5:0]          r_rd_out, r_rd2_out, r_r1_out, r_r2_out;

  entry_t              w_head;
  logic                w_head_valid;
  logic                w_is_alu, w_is_adv, w_is_mem, w_is_br, w_is_ill;
  logic [63:0]         w_wb_clr, w_sb_eff, w_set, w_reg_busy_d;
  logic                w_hazard;
  logic [NUM_ALU-1:0]  w_alu_sel;
  logic                w_alu_free, w_unit_free;
  logic                w_issue, w_drop, w_pop, w_push;

  assign w_head       = r_queue[r_rd_ptr];
  assign w_head_valid = (r_count != '0);
  assign o_in_ready   = (r_count != CntW'(DEPTH));

  assign w_is_alu = ~w_head.unit[2];
  assign w_is_adv = ~w_head.typ & (w_head.unit == 3'd4);
  assign w_is_mem = w_head.typ & (w_head.unit inside {3'd4, 3'd5, 3'd6});
  assign w_is_br  = (w_head.unit == 3'd7);
  assign w_is_ill = ~w_head.typ & (w_head.unit inside {3'd5, 3'd6});

  // Write-backs landing this cycle are already visible to the hazard check.
  always_comb begin
    w_wb_clr = '0;
    if (i_wb0_en) w_wb_clr[i_wb0_rn] = 1'b1;
    if (i_wb1_en) w_wb_clr[i_wb1_rn] = 1'b1;
  end
  assign w_sb_eff = r_reg_busy & ~w_wb_clr;

  assign w_hazard = w_sb_eff[w_head.r1] | w_sb_eff[w_head.r2] | w_sb_eff[w_head.rd] |
                    (w_is_adv & w_sb_eff[w_head.rd2]);

  always_comb begin
    w_alu_sel  = '0;
    w_alu_free = 1'b0;
    for (int i = 0; i < int'(NUM_ALU); i++) begin
      if (!i_alu_busy[i] && !w_alu_free) begin
        w_alu_sel[i] = 1'b1;
        w_alu_free   = 1'b1;
      end
    end
  end

  assign w_unit_free = (w_is_alu & w_alu_free) | (w_is_adv & ~i_advint_busy) |
                       (w_is_mem & ~i_memunit_busy) | (w_is_br & ~i_branch_busy);

  assign w_issue = w_head_valid & ~i_flush & ~w_is_ill & ~w_hazard & w_unit_free;
  assign w_drop  = w_head_valid & ~i_flush & w_is_ill;
  assign w_pop   = w_issue | w_drop;
  assign w_push  = i_in_valid & o_in_ready & ~i_flush;

  // Set is ORed after the clear so a same-edge set wins; r0 is never tracked.
  always_comb begin
    w_set = '0;
    if (w_issue) begin
      w_set[w_head.rd] = 1'b1;
      if (w_is_adv) w_set[w_head.rd2] = 1'b1;
    end
    w_set[0] = 1'b0;
  end
  assign w_reg_busy_d = w_sb_eff | w_set;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_queue[r_wr_ptr] <= '{typ: i_in_type, unit: i_in_unit, r1: i_in_r1_rn,
                             r2: i_in_r2_rn, rd: i_in_rd_rn, rd2: i_in_rd2_rn};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_reg_busy   <= '0;
      r_alu_en     <= '0;
      r_advint_en  <= 1'b0;
      r_memunit_en <= 1'b0;
      r_branch_en  <= 1'b0;
      r_illegal    <= 1'b0;
      r_rd_out     <= '0;
      r_rd2_out    <= '0;
      r_r1_out     <= '0;
      r_r2_out     <= '0;
    end else begin
      r_reg_busy <= w_reg_busy_d;
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
        r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
      end
      r_alu_en     <= (w_issue & w_is_alu) ? w_alu_sel : '0;
      r_advint_en  <= w_issue & w_is_adv;
      r_memunit_en <= w_issue & w_is_mem;
      r_branch_en  <= w_issue & w_is_br;
      r_illegal    <= w_drop;
      if (w_issue) begin
        r_rd_out  <= w_head.rd;
        r_rd2_out <= w_head.rd2;
        r_r1_out  <= w_head.r1;
        r_r2_out  <= w_head.r2;
      end
    end
  end

  assign o_alu_en     = r_alu_en;
  assign o_advint_en  = r_advint_en;
  assign o_memunit_en = r_memunit_en;
  assign o_branch_en  = r_branch_en;
  assign o_illegal    = r_illegal;
  assign o_rd_out_rn  = r_rd_out;
  assign o_rd2_out_rn = r_rd2_out;
  assign o_r1_out_rn  = r_r1_out;
  assign o_r2_out_rn  = r_r2_out;
  assign o_reg_busy   = r_reg_busy;

endmodule

// File: tb/tb_issue_sched.sv
// Bench for issue_sched: directed scenarios plus random traffic, all checked each cycle
// against a queue-based reference model of the scheduling rules.
module tb_issue_sched;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned NUM_ALU = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_in_valid, o_in_ready, i_in_type, i_flush;
  logic [2:0] i_in_unit;
  logic [5:0] i_in_r1_rn, i_in_r2_rn, i_in_rd_rn, i_in_rd2_rn;
  logic i_wb0_en, i_wb1_en;
  logic [5:0] i_wb0_rn, i_wb1_rn;
  logic [NUM_ALU-1:0] o_alu_en, i_alu_busy;
  logic o_advint_en, o_memunit_en, o_branch_en;
  logic i_advint_busy, i_memunit_busy, i_branch_busy;
  logic [5:0] o_rd_out_rn, o_rd2_out_rn, o_r1_out_rn, o_r2_out_rn;
  logic o_illegal;
  logic [63:0] o_reg_busy;

  issue_sched #(.DEPTH(DEPTH), .NUM_ALU(NUM_ALU)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_type(i_in_type), .i_in_unit(i_in_unit),
    .i_in_r1_rn(i_in_r1_rn), .i_in_r2_rn(i_in_r2_rn),
    .i_in_rd_rn(i_in_rd_rn), .i_in_rd2_rn(i_in_rd2_rn),
    .i_flush(i_flush),
    .i_wb0_en(i_wb0_en), .i_wb0_rn(i_wb0_rn), .i_wb1_en(i_wb1_en), .i_wb1_rn(i_wb1_rn),
    .o_alu_en(o_alu_en), .i_alu_busy(i_alu_busy),
    .o_advint_en(o_advint_en), .o_memunit_en(o_memunit_en), .o_branch_en(o_branch_en),
    .i_advint_busy(i_advint_busy), .i_memunit_busy(i_memunit_busy),
    .i_branch_busy(i_branch_busy),
    .o_rd_out_rn(o_rd_out_rn), .o_rd2_out_rn(o_rd2_out_rn),
    .o_r1_out_rn(o_r1_out_rn), .o_r2_out_rn(o_r2_out_rn),
    .o_illegal(o_illegal), .o_reg_busy(o_reg_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       t;
    bit [2:0] u;
    bit [5:0] r1, r2, rd, rd2;
  } ent_t;

  ent_t q[$];
  bit [63:0]        m_sb;
  bit [NUM_ALU-1:0] m_alu;
  bit               m_adv, m_mem, m_br, m_ill;
  bit [23:0]        m_rn;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_sb  = '0;
    m_alu = '0;
    m_adv = 0; m_mem = 0; m_br = 0; m_ill = 0;
    m_rn  = '0;
  endtask

  // One clock of the reference behaviour, from the inputs currently driven.
  task automatic model_eval();
    bit [63:0] eff, setm;
    ent_t h;
    bit is_adv, haz, go, can_push;
    eff = m_sb;
    if (i_wb0_en) eff[i_wb0_rn] = 1'b0;
    if (i_wb1_en) eff[i_wb1_rn] = 1'b0;
    setm = '0;
    m_alu = '0; m_adv = 0; m_mem = 0; m_br = 0; m_ill = 0;
    can_push = (q.size() < DEPTH);
    if (!i_flush && q.size() > 0) begin
      h = q[0];
      if (!h.t && (h.u == 5 || h.u == 6)) begin
        m_ill = 1;
        void'(q.pop_front());
      end else begin
        is_adv = !h.t && h.u == 4;
        haz = eff[h.r1] | eff[h.r2] | eff[h.rd] | (is_adv & eff[h.rd2]);
        go = 0;
        if (!haz) begin
          if (h.u < 4) begin
            for (int i = 0; i < int'(NUM_ALU); i++)
              if (!i_alu_busy[i] && !go) begin m_alu[i] = 1; go = 1; end
          end else if (h.u == 7) begin
            if (!i_branch_busy) begin m_br = 1; go = 1; end
          end else if (is_adv) begin
            if (!i_advint_busy) begin m_adv = 1; go = 1; end
          end else begin
            if (!i_memunit_busy) begin m_mem = 1; go = 1; end
          end
        end
        if (go) begin
          void'(q.pop_front());
          m_rn = {h.rd, h.rd2, h.r1, h.r2};
          setm[h.rd] = 1;
          if (is_adv) setm[h.rd2] = 1;
        end
      end
    end
    setm[0] = 0;
    m_sb = eff | setm;
    if (i_flush) q.delete();
    else if (i_in_valid && can_push)
      q.push_back('{t: i_in_type, u: i_in_unit, r1: i_in_r1_rn, r2: i_in_r2_rn,
                    rd: i_in_rd_rn, rd2: i_in_rd2_rn});
  endtask

  task automatic idle_in();
    i_in_valid = 0; i_in_type = 0; i_in_unit = 0;
    i_in_r1_rn = 0; i_in_r2_rn = 0; i_in_rd_rn = 0; i_in_rd2_rn = 0;
    i_flush = 0; i_wb0_en = 0; i_wb0_rn = 0; i_wb1_en = 0; i_wb1_rn = 0;
  endtask

  task automatic set_in(input bit t, input bit [2:0] u, input bit [5:0] r1, input bit [5:0] r2,
                        input bit [5:0] rd, input bit [5:0] rd2);
    i_in_valid = 1; i_in_type = t; i_in_unit = u;
    i_in_r1_rn = r1; i_in_r2_rn = r2; i_in_rd_rn = rd; i_in_rd2_rn = rd2;
  endtask

  task automatic set_busy(input bit [NUM_ALU-1:0] alu, input bit adv, input bit mem,
                          input bit br);
    i_alu_busy = alu; i_advint_busy = adv; i_memunit_busy = mem; i_branch_busy = br;
  endtask

  // Called at a falling edge with inputs set; advances one clock and compares.
  task automatic step();
    check_eq("in_ready", o_in_ready, q.size() != DEPTH);
    model_eval();
    @(posedge clk);
    @(negedge clk);
    check_eq("en", {o_alu_en, o_advint_en, o_memunit_en, o_branch_en, o_illegal},
             {m_alu, m_adv, m_mem, m_br, m_ill});
    check_eq("out_rn", {o_rd_out_rn, o_rd2_out_rn, o_r1_out_rn, o_r2_out_rn}, m_rn);
    check_eq("reg_busy", o_reg_busy, m_sb);
  endtask

  task automatic rand_in();
    idle_in();
    if ($urandom_range(0, 99) < 60)
      set_in(1'($urandom), 3'($urandom), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
             6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)));
    i_flush  = ($urandom_range(0, 99) < 3);
    i_wb0_en = ($urandom_range(0, 99) < 30); i_wb0_rn = 6'($urandom_range(0, 7));
    i_wb1_en = ($urandom_range(0, 99) < 20); i_wb1_rn = 6'($urandom_range(0, 7));
    for (int i = 0; i < int'(NUM_ALU); i++) i_alu_busy[i] = ($urandom_range(0, 3) == 0);
    i_advint_busy  = ($urandom_range(0, 3) == 0);
    i_memunit_busy = ($urandom_range(0, 3) == 0);
    i_branch_busy  = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    idle_in();
    set_busy('0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_busy", o_reg_busy, 64'h0);
    check_eq("rst_en", {o_alu_en, o_advint_en, o_memunit_en, o_branch_en, o_illegal}, 0);
    rst_n = 1;
    @(negedge clk);
    check_eq("rst_rdy", o_in_ready, 1);
    check_eq("rst_rn", {o_rd_out_rn, o_rd2_out_rn, o_r1_out_rn, o_r2_out_rn}, 0);

    // Single ALU op: two-edge latency, one-cycle enable
    set_in(0, 3'd0, 6'd1, 6'd2, 6'd3, 6'd0); step();
    idle_in(); step();
    check_eq("alu1_en", o_alu_en, 2'b01);
    check_eq("alu1_rd", o_rd_out_rn, 6'd3);
    check_eq("alu1_sb3", o_reg_busy[3], 1);
    step();
    check_eq("alu1_pulse", o_alu_en, 2'b00);

    // RAW dependency resolved by write-back bypass
    set_in(0, 3'd1, 6'd0, 6'd0, 6'd5, 6'd0); step();
    set_in(0, 3'd2, 6'd5, 6'd0, 6'd6, 6'd0); step();
    idle_in(); repeat (3) step();
    check_eq("raw_stall", o_alu_en, 2'b00);
    i_wb0_en = 1; i_wb0_rn = 6'd5; step();
    check_eq("raw_issue", o_alu_en, 2'b01);
    check_eq("raw_r1", o_r1_out_rn, 6'd5);
    idle_in(); i_wb0_en = 1; i_wb0_rn = 6'd6; step();
    i_wb0_rn = 6'd3; step();
    idle_in();

    // ALU selection around busy units
    set_busy(2'b01, 0, 0, 0);
    set_in(0, 3'd0, 6'd0, 6'd0, 6'd10, 6'd0); step();
    set_in(0, 3'd3, 6'd0, 6'd0, 6'd11, 6'd0); step();
    check_eq("alusel_first", o_alu_en, 2'b10);
    idle_in(); set_busy(2'b11, 0, 0, 0); repeat (2) step();
    set_busy(2'b10, 0, 0, 0); step();
    step();
    set_busy('0, 0, 0, 0);

    // Fill the queue while everything is busy
    set_busy(2'b11, 1, 1, 1);
    for (int k = 0; k < int'(DEPTH); k++) begin
      set_in(0, 3'(k % 4), 6'd0, 6'd0, 6'd0, 6'd0); step();
    end
    check_eq("full_rdy", o_in_ready, 0);
    set_in(0, 3'd1, 6'd0, 6'd0, 6'd0, 6'd0); set_busy(2'b10, 1, 1, 1); step();
    step(); step();
    idle_in(); set_busy('0, 0, 0, 0); repeat (DEPTH + 1) step();

    // Undecodable head is dropped; next entry issues the following cycle
    set_in(0, 3'd5, 6'd0, 6'd0, 6'd20, 6'd0); step();
    set_in(0, 3'd0, 6'd0, 6'd0, 6'd21, 6'd0); step();
    check_eq("ill_pulse", o_illegal, 1);
    check_eq("ill_noen", {o_alu_en, o_advint_en, o_memunit_en, o_branch_en}, 0);
    idle_in(); step();
    check_eq("ill_next", o_alu_en, 2'b01);
    check_eq("ill_pulse_end", o_illegal, 0);

    // Flush with three queued entries and a concurrent write-back
    set_busy(2'b11, 1, 1, 1);
    for (int k = 0; k < 3; k++) begin
      set_in(1, 3'd4, 6'd0, 6'd0, 6'(30 + k), 6'd0); step();
    end
    idle_in(); i_flush = 1; i_in_valid = 1; i_wb0_en = 1; i_wb0_rn = 6'd21; step();
    check_eq("flush_rdy", o_in_ready, 1);
    check_eq("flush_wb", o_reg_busy[21], 0);
    idle_in(); set_busy('0, 0, 0, 0); repeat (2) step();

    // Advanced-integer op sets both destinations
    set_in(0, 3'd4, 6'd0, 6'd0, 6'd40, 6'd41); step();
    idle_in(); step();
    check_eq("adv_en", o_advint_en, 1);
    check_eq("adv_sb", o_reg_busy[41:40], 2'b11);

    for (int n = 0; n < 1500; n++) begin
      rand_in(); step();
    end

    // Asynchronous reset mid-run
    rand_in();
    #2 rst_n = 0;
    #1;
    model_reset();
    check_eq("arst_busy", o_reg_busy, 64'h0);
    check_eq("arst_en", {o_alu_en, o_advint_en, o_memunit_en, o_branch_en, o_illegal}, 0);
    check_eq("arst_rdy", o_in_ready, 1);
    @(negedge clk);
    rst_n = 1;
    for (int n = 0; n < 1500; n++) begin
      rand_in(); step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
